// File: rtl/spad_stream_reader.sv
// Strided scratchpad read client with a 2-entry skid FIFO.
// Turns a start command into SPad reads and a valid/ready word stream.
module spad_stream_reader #(
  parameter int DATA_BITWIDTH  = 16,
  parameter int ADDR_BITWIDTH  = 9,
  parameter int COUNT_BITWIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_BITWIDTH-1:0]  base_addr,
  input  logic [ADDR_BITWIDTH-1:0]  stride,
  input  logic [COUNT_BITWIDTH-1:0] count,
  output logic                      busy,
  output logic                      done,
  output logic                      spad_read_req,
  output logic [ADDR_BITWIDTH-1:0]  spad_r_addr,
  input  logic [DATA_BITWIDTH-1:0]  spad_r_data,
  output logic [DATA_BITWIDTH-1:0]  out_data,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [ADDR_BITWIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_BITWIDTH-1:0]  stride_q, stride_d;
  logic [COUNT_BITWIDTH-1:0] count_q, count_d;
  logic [COUNT_BITWIDTH-1:0] issued_q, issued_d;
  logic                      inflight_q;

  logic [DATA_BITWIDTH-1:0]  fifo_q [2];
  logic                      wr_ptr_q;
  logic                      rd_ptr_q;
  logic [1:0]                fifo_cnt_q;

  logic                      push;
  logic                      pop;
  logic [2:0]                credit;
  logic                      drain_empty;
  logic [COUNT_BITWIDTH-1:0] issued_inc;

  // Stream side: FIFO head and handshake; returned data lands one cycle after a read.
  always_comb begin
    out_valid   = (fifo_cnt_q != 2'd0);
    out_data    = fifo_q[rd_ptr_q];
    pop         = out_valid && out_ready;
    push        = inflight_q;
    credit      = {1'b0, fifo_cnt_q}
                + {2'b00, inflight_q}
                - {2'b00, pop};
    drain_empty = !inflight_q
               && ((fifo_cnt_q == 2'd0)
               ||  ((fifo_cnt_q == 2'd1) && pop));
    issued_inc  = issued_q + 1'b1;
  end

  // Next-state, read issue and status outputs.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    stride_d      = stride_q;
    count_d       = count_q;
    issued_d      = issued_q;
    spad_read_req = 1'b0;
    spad_r_addr   = addr_q;
    busy          = (state_q != IDLE);
    done          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          stride_d = stride;
          count_d  = count;
          issued_d = '0;
          state_d  = (count != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (credit < 3'd2) begin
          spad_read_req = 1'b1;
          addr_d        = addr_q + stride_q;
          issued_d      = issued_inc;
          if (issued_inc == count_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      inflight_q <= spad_read_req;
    end
  end

  // Skid FIFO storage and pointers; pushes never hit a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= spad_r_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      fifo_cnt_q <= fifo_cnt_q
                  + {1'b0, push}
                  - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_spad_stream_reader.sv
// Bench for spad_stream_reader: SPad memory model,
// expected-stream scoreboard and directed scenarios.
module tb_spad_stream_reader;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int CW = 10;
  localparam int MEMSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] stride;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic          spad_read_req;
  logic [AW-1:0] spad_r_addr;
  logic [DW-1:0] spad_r_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  spad_stream_reader #(
    .DATA_BITWIDTH (DW),
    .ADDR_BITWIDTH (AW),
    .COUNT_BITWIDTH(CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .stride       (stride),
    .count        (count),
    .busy         (busy),
    .done         (done),
    .spad_read_req(spad_read_req),
    .spad_r_addr  (spad_r_addr),
    .spad_r_data  (spad_r_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic int memv(input int a);
    return (a % MEMSZ) + 100;
  endfunction

  // SPad: 1-cycle read latency, filler value when not reading.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    spad_r_data <= spad_read_req ?
      DW'(memv(int'(spad_r_addr))) : 16'hBEEF;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model state
  logic mbusy = 1'b0;
  logic done_due = 1'b0;
  logic was_idle;
  logic hs;
  int   exp_addr[$];
  int   exp_data[$];
  int   outstanding = 0;
  int   got[$];
  int   addr_log[$];
  int   start_cyc = -1;
  int   first_req_cyc = -1;
  int   first_valid_cyc = -1;
  int   done_cyc = -1;

  // Per-cycle comparison against the transfer model.
  always @(negedge clk) begin
    if (reset) begin
      mbusy = 1'b0;
      done_due = 1'b0;
      exp_addr.delete();
      exp_data.delete();
      outstanding = 0;
    end else begin
      was_idle = !mbusy;
      chk("busy", int'(busy), int'(mbusy));
      chk("done", int'(done), int'(done_due));
      if (done) done_cyc = cyc;
      if (done_due) begin
        mbusy = 1'b0;
        done_due = 1'b0;
      end
      hs = out_valid && out_ready;
      if (spad_read_req) begin
        if (first_req_cyc < 0) first_req_cyc = cyc;
        addr_log.push_back(int'(spad_r_addr));
        if (exp_addr.size() == 0)
          chk("req_unexpected", 1, 0);
        else
          chk("addr", int'(spad_r_addr), exp_addr.pop_front());
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (hs) begin
        got.push_back(int'(out_data));
        if (exp_data.size() == 0)
          chk("valid_unexpected", 1, 0);
        else
          chk("data", int'(out_data), exp_data.pop_front());
      end
      outstanding = outstanding + int'(spad_read_req) - int'(hs);
      if (spad_read_req) chk("outstanding_le2", int'(outstanding <= 2), 1);
      if (hs && mbusy && exp_data.size() == 0 && exp_addr.size() == 0)
        done_due = 1'b1;
      if (start && was_idle) begin
        mbusy = 1'b1;
        start_cyc = cyc;
        for (int k = 0; k < int'(count); k++) begin
          int a;
          a = (int'(base_addr) + k * int'(stride)) % MEMSZ;
          exp_addr.push_back(a);
          exp_data.push_back(memv(a));
        end
        if (count == '0) done_due = 1'b1;
      end
    end
  end

  // out_ready driver: held high or toggling 1,0,0,1,0,1,...
  logic rdy_mode = 1'b0;
  int   pidx = 0;
  int   pat[6] = '{1, 0, 0, 1, 0, 1};
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) begin
        out_ready = pat[pidx % 6] != 0;
        pidx++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic clear_log();
    got.delete();
    addr_log.delete();
    start_cyc = -1;
    first_req_cyc = -1;
    first_valid_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic pulse_start(input int b, input int s, input int c);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = AW'(b);
    stride = AW'(s);
    count = CW'(c);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (mbusy && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (mbusy) chk({name, "_timeout"}, 1, 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_req"}, int'(spad_read_req), 0);
    chk({name, "_addr"}, int'(spad_r_addr), 0);
    chk({name, "_valid"}, int'(out_valid), 0);
    chk({name, "_data"}, int'(out_data), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    stride = '0;
    count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Unit stride, full throughput
    clear_log();
    pulse_start(4, 1, 5);
    wait_idle("t1");
    chk("t1_req_lat", first_req_cyc - start_cyc, 1);
    chk("t1_valid_lat", first_valid_cyc - start_cyc, 3);
    chk("t1_done_lat", done_cyc - start_cyc, 8);
    chk("t1_n", got.size(), 5);
    chk("t1_d0", got[0], 104);
    chk("t1_d4", got[4], 108);
    chk("t1_a0", addr_log[0], 4);
    chk("t1_a4", addr_log[4], 8);

    // Address wrap
    clear_log();
    pulse_start(510, 3, 3);
    wait_idle("t2");
    chk("t2_n", got.size(), 3);
    chk("t2_d0", got[0], 610);
    chk("t2_d1", got[1], 101);
    chk("t2_d2", got[2], 104);
    chk("t2_a1", addr_log[1], 1);
    chk("t2_a2", addr_log[2], 4);

    // Zero-length transfer
    clear_log();
    pulse_start(7, 1, 0);
    wait_idle("t3");
    chk("t3_done_lat", done_cyc - start_cyc, 1);
    chk("t3_reqs", addr_log.size(), 0);
    chk("t3_valid", first_valid_cyc, -1);

    // Backpressure pattern
    clear_log();
    pidx = 0;
    rdy_mode = 1'b1;
    pulse_start(0, 1, 8);
    wait_idle("t4");
    rdy_mode = 1'b0;
    chk("t4_n", got.size(), 8);
    for (int i = 0; i < 8; i++) chk("t4_d", got[i], 100 + i);

    // Reset mid-transfer
    clear_log();
    pulse_start(20, 1, 10);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("t5_valid_seen", int'(out_valid), 1);
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("t5");
    repeat (10) @(posedge clk);
    chk("t5_no_done", done_cyc, -1);
    clear_log();
    pulse_start(50, 2, 3);
    wait_idle("t5b");
    chk("t5b_n", got.size(), 3);
    chk("t5b_d0", got[0], 150);
    chk("t5b_d2", got[2], 154);

    // Start pulse during an active transfer is ignored
    clear_log();
    pulse_start(30, 1, 4);
    pulse_start(200, 1, 2);
    wait_idle("t6");
    chk("t6_n", got.size(), 4);
    chk("t6_d0", got[0], 130);
    chk("t6_d3", got[3], 133);
    chk("t6_a3", addr_log[3], 33);

    // Maximum transfer length
    clear_log();
    pulse_start(0, 1, 1023);
    wait_idle("t7");
    chk("t7_n", got.size(), 1023);
    chk("t7_dlast", got[1022], 610);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
